inv_mixcol: RTL and testbench

Iterative AES InvMixColumns unit for the decryption datapath. It transforms the state back through the inverse of the forward mix-columns stage. It latches a 128-bit state on a start pulse, processes COLS_PER_CYCLE columns per clock, and presents the registered result with a one-cycle done pulse. The decrypt round controller instantiates it between InvShiftRows/InvSubBytes and AddRoundKey.

---
 rtl/inv_mixcol.sv | 119 +++++++++++
 tb/tb_inv_mixcol.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_mixcol.sv
// Iterative AES InvMixColumns: latches a 128-bit state on start, transforms
// COLS_PER_CYCLE columns per clock and presents the result with a done pulse.
module inv_mixcol #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t       state, state_nxt;
  logic [1:0]   col_cnt;
  logic [127:0] work, work_mixed;
  logic         load, step, finish, last_grp;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column (s0,s1,s2,s3) packed MSB-first; multiples built from chained xtime.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Groups are aligned, so col_cnt + g never runs past column 3.
  always_comb begin : mix_group
    int          idx;
    logic [31:0] col;
    logic [31:0] mixed;
    work_mixed = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx   = int'(col_cnt) + g;
      col   = {work[127-8*idx -: 8], work[95-8*idx -: 8],
               work[63-8*idx -: 8],  work[31-8*idx -: 8]};
      mixed = inv_col(col);
      work_mixed[127-8*idx -: 8] = mixed[31:24];
      work_mixed[95-8*idx -: 8]  = mixed[23:16];
      work_mixed[63-8*idx -: 8]  = mixed[15:8];
      work_mixed[31-8*idx -: 8]  = mixed[7:0];
    end
  end

  assign last_grp = (col_cnt == LAST_COL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_grp) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == RUN);
    finish = step && last_grp;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col_cnt  <= 2'd0;
      work     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (load) begin
        work    <= data_in;
        col_cnt <= 2'd0;
        busy    <= 1'b1;
      end
      if (step) begin
        work    <= work_mixed;
        col_cnt <= col_cnt + COL_STEP;
      end
      if (finish) begin
        data_out <= work_mixed;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_mixcol.sv
// Bench for inv_mixcol: three instances (1, 2, 4 columns per cycle) checked
// every cycle against a GF(2^8) matrix model plus literal spot checks.
module tb_inv_mixcol;

  localparam logic [127:0] K    = 128'h8e9f01d5_4ddc01d5_a15801d7_bc9d01d6;
  localparam logic [127:0] KOUT = 128'hdbf201d4_130a01d4_532201d4_455c01d5;
  localparam logic [127:0] ONES = 128'h01010101_01010101_01010101_01010101;
  localparam logic [31:0]  INV_ROW = 32'h0e0b0d09;
  localparam logic [31:0]  FWD_ROW = 32'h02030101;

  logic clk, rst;
  logic start1, start2, start4;
  logic [127:0] din1, din2, din4, dout1, dout2, dout4;
  logic busy1, busy2, busy4, done1, done2, done4;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Model state per instance: outstanding request, its accept edge and result.
  bit           pend [3];
  int           acc  [3];
  int           ready[3];
  logic [127:0] val  [3];
  logic [127:0] last [3];
  int           lat  [3] = '{4, 2, 1};

  inv_mixcol #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .data_in(din1),
    .data_out(dout1), .busy(busy1), .done(done1));
  inv_mixcol #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .start(start2), .data_in(din2),
    .data_out(dout2), .busy(busy2), .done(done2));
  inv_mixcol #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .data_in(din4),
    .data_out(dout4), .busy(busy4), .done(done4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix multiply over every column; row 0 of the matrix is m.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] m);
    logic [127:0] o;
    logic [7:0]   acc_b;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc_b = 8'h00;
        for (int j = 0; j < 4; j++)
          acc_b ^= gmul(m[31-8*((j-r+4)%4) -: 8], s[127-32*j-8*c -: 8]);
        o[127-32*r-8*c -: 8] = acc_b;
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mix(s, INV_ROW);
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    return mix(s, FWD_ROW);
  endfunction

  task automatic model_step(input int i, input logic st, input logic [127:0] din,
                            input logic b, input logic d, input logic [127:0] dout);
    logic busy_exp, done_exp;
    if (rst) begin
      pend[i]  = 1'b0;
      last[i]  = '0;
      ready[i] = cyc + 1;
      check($sformatf("rst_busy%0d", i), b, 0);
      check($sformatf("rst_done%0d", i), d, 0);
      check($sformatf("rst_dout%0d", i), dout, 0);
      return;
    end
    if (!pend[i] && st && cyc >= ready[i]) begin
      pend[i] = 1'b1;
      acc[i]  = cyc;
      val[i]  = ref_inv(din);
    end
    busy_exp = pend[i] && (cyc < acc[i] + lat[i]);
    done_exp = pend[i] && (cyc == acc[i] + lat[i]);
    if (done_exp) begin
      last[i]  = val[i];
      pend[i]  = 1'b0;
      ready[i] = cyc + 2;
    end
    check($sformatf("busy%0d", i), b, busy_exp);
    check($sformatf("done%0d", i), d, done_exp);
    check($sformatf("dout%0d", i), dout, last[i]);
  endtask

  // Single compare process: samples just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    model_step(0, start1, din1, busy1, done1, dout1);
    model_step(1, start2, din2, busy2, done2, dout2);
    model_step(2, start4, din4, busy4, done4, dout4);
  end

  task automatic wait_done1();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done1 && t < 20);
    check("done1_seen", done1, 1);
  endtask

  task automatic run1(input logic [127:0] d);
    @(negedge clk); start1 = 1'b1; din1 = d;
    @(negedge clk); start1 = 1'b0; din1 = ~d;
    wait_done1();
  endtask

  initial begin : driver
    int dones, gaps, prev_done;
    logic [127:0] r;
    rst = 1'b1;
    start1 = 0; start2 = 0; start4 = 0;
    din1 = '0; din2 = '0; din4 = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; ready[i] = 0; last[i] = '0; acc[i] = 0; val[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("model_known", ref_inv(K), KOUT);
    check("model_zero",  ref_inv('0), '0);
    check("model_ones",  ref_inv(ONES), ONES);
    check("model_fwd",   ref_fwd(KOUT), K);

    run1(K);
    check("known_out", dout1, KOUT);
    run1('0);
    check("zero_out", dout1, '0);
    run1(ONES);
    check("ones_out", dout1, ONES);

    // Second start two cycles after accept must be ignored.
    @(negedge clk); start1 = 1'b1; din1 = K;
    @(negedge clk); start1 = 1'b0; din1 = '0;
    @(negedge clk); start1 = 1'b1; din1 = ONES;
    @(negedge clk); start1 = 1'b0;
    wait_done1();
    check("ignored_out", dout1, KOUT);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1) dones++;
    end
    check("single_done", 128'(dones), 0);

    // Reset two cycles after accept aborts; start right after reset is taken.
    @(negedge clk); start1 = 1'b1; din1 = K;
    @(negedge clk); start1 = 1'b0; din1 = '0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_busy", busy1, 0);
    check("abort_dout", dout1, '0);
    @(negedge clk); rst = 1'b0; start1 = 1'b1; din1 = ONES;
    @(negedge clk); start1 = 1'b0; din1 = K;
    wait_done1();
    check("post_rst_out", dout1, ONES);
    run1(K);
    check("post_rst_known", dout1, KOUT);

    // Start held high: one result every 6 cycles.
    @(negedge clk); start1 = 1'b1; din1 = K;
    dones = 0; gaps = 0; prev_done = -1;
    repeat (40) begin
      @(negedge clk);
      if (done1) begin
        if (prev_done >= 0) check("b2b_gap", 128'(cyc - prev_done), 6);
        prev_done = cyc;
        dones++;
      end
    end
    check("b2b_count", 128'(dones >= 5), 1);
    start1 = 1'b0;
    repeat (10) @(negedge clk);

    // Random sweep on the 2- and 4-column instances; dut4 also does a round trip.
    for (int j = 0; j < 1000; j++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      start2 = 1'b1; din2 = r;
      start4 = 1'b1; din4 = ref_fwd(r);
      @(negedge clk);
      start2 = 1'b0; din2 = ~r;
      start4 = 1'b0; din4 = r;
      repeat (4) @(negedge clk);
      check("roundtrip4", dout4, r);
    end
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
